// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Time-multiplexes a NUM_DIGITS-wide hex value onto a shared 7-segment bus.
// A newly loaded value is buffered and only reaches the display at a frame
// boundary, so a frame never shows a mix of old and new digits. Leading
// zero digits can optionally be blanked.

module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Value,
    output logic [3:0]              Digit,
    output logic [NUM_DIGITS-1:0]   DigitSel,
    output logic                    Blank,
    output logic                    Frame
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] hold;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    pend;
    logic                    frameQ;

    logic                    cntLast;
    logic                    wrapEvent;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lzMask;
    logic                    zeroRun;

    assign cntLast   = (cnt == CNT_LAST);
    assign wrapEvent = Enable && cntLast && (idx == IDX_LAST);

    // Prescaler and digit index; both freeze while Enable is low so the
    // scan resumes exactly where it stopped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (Enable) begin
            if (cntLast) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Frame marker is registered so it lines up with idx returning to zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frameQ <= 1'b0;
        end else begin
            frameQ <= wrapEvent;
        end
    end

    // A pulse left over from a wrap must not leak out while the display is dark.
    assign Frame = frameQ && Enable;

    // Load buffering: Value is parked in hold and copied into disp only on a
    // wrap; a Load landing exactly on the wrap goes straight to disp.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold <= '0;
            disp <= '0;
            pend <= 1'b0;
        end else if (Load && wrapEvent) begin
            hold <= Value;
            disp <= Value;
            pend <= 1'b0;
        end else if (Load) begin
            hold <= Value;
            pend <= 1'b1;
        end else if (wrapEvent && pend) begin
            disp <= hold;
            pend <= 1'b0;
        end
    end

    // Split the display register into per-digit nibbles and find the run of
    // zero digits counted down from the most significant end. Digit 0 is
    // never part of the run so a zero value still shows a single "0".
    always_comb begin
        zeroRun = 1'b1;
        lzMask  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = disp[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeroRun   = zeroRun && (nib[i] == 4'h0);
            lzMask[i] = zeroRun;
        end
    end

    // Drive the decoder nibble, the one-cold anode select and the blank flag.
    always_comb begin
        Digit    = nib[idx];
        DigitSel = '1;
        Blank    = 1'b1;
        if (Enable) begin
            DigitSel[idx] = 1'b0;
            Blank         = (LZ_BLANK != 0) && lzMask[idx];
        end
    end

endmodule
